// File: rtl/dl_pkg.sv
// Shared types for the ROM download sequencer: FSM states, FIFO entry layout
// and the hps_io address width.
package dl_pkg;

  localparam int unsigned IOCTL_AW  = 25;
  localparam int unsigned DL_ADDR_W = 17;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    LOAD,
    DRAIN,
    HOLD
  } dl_state_t;

  typedef struct packed {
    logic [DL_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } dl_entry_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with occupancy count and a synchronous flush.
// A push while full is only taken if a pop frees a slot in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dl_rom_sequencer.sv
// Bridges the hps_io download port to the core ROM load port: buffers bytes,
// filters out-of-image addresses and holds the core in reset around a load.
module dl_rom_sequencer
  import dl_pkg::*;
#(
  parameter int unsigned ADDR_W      = DL_ADDR_W,
  parameter int unsigned ROM_SIZE    = 32'h1C000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 256
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic                ioctl_wait,
  output logic [ADDR_W-1:0]   dn_addr,
  output logic [7:0]          dn_data,
  output logic                dn_wr,
  input  logic                dn_ready,
  output logic                core_reset,
  output logic                dl_overflow,
  output logic [ADDR_W:0]     dl_bytes
);

  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned HOLD_W   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned ENTRY_W  = $bits(dl_entry_t);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

  dl_state_t          state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               dl_prev;
  logic               dl_rise;
  logic               in_range;
  logic               push_req;
  logic               slot_free;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  dl_entry_t          push_entry;
  dl_entry_t          head_entry;
  logic [ENTRY_W-1:0] fifo_dout;

  assign dl_rise    = ioctl_download & ~dl_prev;
  assign in_range   = (ioctl_addr < IOCTL_AW'(ROM_SIZE));
  // Accept only in LOAD; this also covers the cycle download falls, since the
  // state moves to DRAIN one edge later.
  assign push_req   = ioctl_wr & in_range & (state == LOAD) & ~dl_rise;
  assign slot_free  = ~dn_wr | dn_ready;
  assign fifo_pop   = slot_free & ~fifo_empty & ~dl_rise;
  assign push_entry = '{addr: DL_ADDR_W'(ioctl_addr), data: ioctl_dout};
  assign head_entry = fifo_dout;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .clr   (dl_rise),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (push_entry),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      hold_cnt    <= HOLD_MAX;
      core_reset  <= 1'b1;
      dl_prev     <= 1'b0;
      ioctl_wait  <= 1'b0;
      dn_wr       <= 1'b0;
      dn_addr     <= '0;
      dn_data     <= '0;
      dl_overflow <= 1'b0;
      dl_bytes    <= '0;
    end else begin
      dl_prev    <= ioctl_download;
      ioctl_wait <= (fifo_count >= CNT_W'(FIFO_DEPTH - 1));

      if (dl_rise) begin
        // A new download restarts from any state and drops any pending write.
        state       <= LOAD;
        core_reset  <= 1'b1;
        dl_overflow <= 1'b0;
        dl_bytes    <= '0;
        dn_wr       <= 1'b0;
      end else begin
        if (push_req && fifo_full && !fifo_pop) begin
          dl_overflow <= 1'b1;
        end
        if (dn_wr && dn_ready && !dl_bytes[ADDR_W]) begin
          dl_bytes <= dl_bytes + (ADDR_W+1)'(1);
        end
        if (slot_free) begin
          dn_wr <= ~fifo_empty;
          if (!fifo_empty) begin
            dn_addr <= ADDR_W'(head_entry.addr);
            dn_data <= head_entry.data;
          end
        end

        case (state)
          BOOT, HOLD: begin
            core_reset <= 1'b1;
            if (hold_cnt == '0) begin
              state      <= RUN;
              core_reset <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - HOLD_W'(1);
            end
          end
          RUN: begin
            core_reset <= 1'b0;
          end
          LOAD: begin
            core_reset <= 1'b1;
            if (!ioctl_download) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            core_reset <= 1'b1;
            // Settle time starts on the edge the last write completes.
            if (fifo_empty && slot_free) begin
              state    <= HOLD;
              hold_cnt <= HOLD_MAX;
            end
          end
          default: begin
            state      <= BOOT;
            hold_cnt   <= HOLD_MAX;
            core_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dl_rom_sequencer.sv
// Directed bench for dl_rom_sequencer: expected writes are queued by the
// stimulus and matched against every completed core write.
module tb_dl_rom_sequencer;

  localparam int unsigned HOLD = 256;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        dn_ready;
  logic        core_reset;
  logic        dl_overflow;
  logic [17:0] dl_bytes;

  dl_rom_sequencer #(
    .ADDR_W      (17),
    .ROM_SIZE    (32'h1C000),
    .FIFO_DEPTH  (4),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_sys        (clk),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_ready       (dn_ready),
    .core_reset     (core_reset),
    .dl_overflow    (dl_overflow),
    .dl_bytes       (dl_bytes)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [16:0] a;
    logic [7:0]  d;
  } exp_t;
  exp_t expq[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && dn_wr === 1'b1 && dn_ready === 1'b1) begin
      if (expq.size() == 0) begin
        check_eq("unexpected_wr", {15'd0, dn_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check_eq("wr_addr", {15'd0, dn_addr}, {15'd0, e.a});
        check_eq("wr_data", {24'd0, dn_data}, {24'd0, e.d});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input bit keep);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (keep) expq.push_back('{a: a[16:0], d: d});
    tick();
    ioctl_wr = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 2000) begin
      @(negedge clk);
      if (!core_reset) break;
      n++;
    end
    check_eq("idle_timeout", (n < 2000), 1);
    tick();
  endtask

  initial begin
    int cnt;
    int boot_wr;
    int sent;
    int saw_wait;
    logic [7:0] d;

    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    dn_ready       = 1'b1;
    #23;
    check_eq("rst_core_reset", core_reset, 1);
    check_eq("rst_dn_wr", dn_wr, 0);
    check_eq("rst_wait", ioctl_wait, 0);
    check_eq("rst_bytes", dl_bytes, 0);
    check_eq("rst_ovf", dl_overflow, 0);

    // Power-on settle
    @(posedge clk);
    #1 reset_n = 1'b1;
    cnt = 0;
    boot_wr = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      boot_wr |= dn_wr;
      if (!core_reset) break;
      cnt++;
    end
    check_eq("boot_hold", cnt, HOLD);
    check_eq("boot_dn_wr", boot_wr, 0);
    tick();

    // 16-byte download, strobe every 2 cycles
    start_dl();
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 17 + 3);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = d;
      expq.push_back('{a: 17'(i), d: d});
      tick();
      ioctl_wr = 1'b0;
      if (i == 15) ioctl_download = 1'b0;
      tick();
    end
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dn_wr && dn_ready) cnt = 0;
      else if (core_reset) cnt++;
      else break;
    end
    check_eq("post_wr_hold", cnt, HOLD);
    check_eq("t2_bytes", dl_bytes, 16);
    check_eq("t2_ovf", dl_overflow, 0);
    check_eq("t2_queue", expq.size(), 0);
    tick();

    // Back-pressure with a host that honours ioctl_wait
    start_dl();
    dn_ready = 1'b0;
    sent = 0;
    saw_wait = 0;
    for (int c = 0; c < 20; c++) begin
      if (ioctl_wait) begin
        saw_wait = 1;
        ioctl_wr = 1'b0;
      end else begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h100 + 25'(sent);
        ioctl_dout = 8'hA0 + 8'(sent);
        expq.push_back('{a: 17'h100 + 17'(sent), d: 8'hA0 + 8'(sent)});
        sent++;
      end
      tick();
    end
    ioctl_wr = 1'b0;
    check_eq("t3_wait_seen", saw_wait, 1);
    check_eq("t3_sent", sent, 5);
    check_eq("t3_ovf", dl_overflow, 0);
    check_eq("t3_slot_held", dn_wr, 1);
    dn_ready       = 1'b1;
    ioctl_download = 1'b0;
    wait_idle();
    check_eq("t3_bytes", dl_bytes, 5);
    check_eq("t3_queue", expq.size(), 0);

    // Host ignores wait: sixth byte is dropped
    start_dl();
    dn_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h200 + 25'(i);
      ioctl_dout = 8'h50 + 8'(i);
      if (i < 5) expq.push_back('{a: 17'h200 + 17'(i), d: 8'h50 + 8'(i)});
      tick();
    end
    ioctl_wr = 1'b0;
    tick();
    check_eq("t4_ovf", dl_overflow, 1);
    check_eq("t4_wait", ioctl_wait, 1);
    dn_ready       = 1'b1;
    ioctl_download = 1'b0;
    wait_idle();
    check_eq("t4_bytes", dl_bytes, 5);
    check_eq("t4_ovf_sticky", dl_overflow, 1);
    check_eq("t4_queue", expq.size(), 0);

    // Address boundary, plus a high address whose low bits alias into range
    start_dl();
    check_eq("t5_ovf_cleared", dl_overflow, 0);
    check_eq("t5_bytes_cleared", dl_bytes, 0);
    strobe(25'h1BFFF, 8'h5A, 1'b1);
    strobe(25'h1C000, 8'hC3, 1'b0);
    strobe(25'h1000000, 8'h77, 1'b0);
    ioctl_download = 1'b0;
    wait_idle();
    check_eq("t5_bytes", dl_bytes, 1);
    check_eq("t5_ovf", dl_overflow, 0);
    check_eq("t5_queue", expq.size(), 0);

    // Restart during HOLD, then async reset mid-LOAD
    start_dl();
    strobe(25'h33, 8'h99, 1'b1);
    ioctl_download = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_eq("t6_bytes_before", dl_bytes, 1);
    check_eq("t6_in_hold", core_reset, 1);
    ioctl_download = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (core_reset) cnt++;
    end
    check_eq("t6_restart_reset", cnt, 4);
    check_eq("t6_bytes_cleared", dl_bytes, 0);
    tick();
    dn_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'h44 + 25'(i);
      ioctl_dout = 8'hE1 + 8'(i);
      tick();
    end
    ioctl_wr = 1'b0;
    tick();
    check_eq("t6_pre_dn_wr", dn_wr, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_core_reset", core_reset, 1);
    check_eq("t6_rst_dn_wr", dn_wr, 0);
    check_eq("t6_rst_dn_addr", dn_addr, 0);
    check_eq("t6_rst_dn_data", dn_data, 0);
    check_eq("t6_rst_wait", ioctl_wait, 0);
    check_eq("t6_rst_ovf", dl_overflow, 0);
    check_eq("t6_rst_bytes", dl_bytes, 0);
    ioctl_download = 1'b0;
    dn_ready       = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("t6_after_rst_dn_wr", dn_wr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
